// File: rtl/bilinear_col_interp_if.sv
// Bus between the column interpolator and its surroundings: line control,
// the shared row-buffer read port and the output pixel stream.
interface bilinear_col_interp_if;
    logic        line_start;
    logic [9:0]  src_width;
    logic [10:0] dst_width;
    logic [8:0]  x_step;
    logic [7:0]  fy;
    logic [9:0]  rd_row_addr;
    logic [7:0]  row0_pixel;
    logic [7:0]  row1_pixel;
    logic [7:0]  out_pixel;
    logic        out_data_en;
    logic        busy;
    logic        line_done;

    // Line controller / row buffers side
    modport master (
        output line_start, src_width, dst_width, x_step, fy, row0_pixel, row1_pixel,
        input  rd_row_addr, out_pixel, out_data_en, busy, line_done
    );

    // Interpolator side
    modport slave (
        input  line_start, src_width, dst_width, x_step, fy, row0_pixel, row1_pixel,
        output rd_row_addr, out_pixel, out_data_en, busy, line_done
    );
endinterface

// File: rtl/bilinear_col_interp.sv
// Horizontal+vertical bilinear interpolator for one destination line.
// Each destination pixel is fetched as two reads (A: left column, B: right
// column) from the upper and lower row buffers, so one pixel leaves every
// two clocks. A tag line tracks which read phase and fraction each returning
// word belongs to.
module bilinear_col_interp #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    bilinear_col_interp_if.slave bus
);

    typedef enum logic [2:0] {IDLE, ISSUE_A, ISSUE_B, DRAIN, DONE} state_t;

    state_t      state;
    logic [17:0] x_acc;          // Q10.8 source position
    logic [8:0]  x_step_l;
    logic [7:0]  fy_l;
    logic [9:0]  src_w_l;
    logic [10:0] dst_w_l;
    logic [10:0] issue_cnt;
    logic [9:0]  rd_addr;
    logic        busy_r;
    logic        done_r;

    logic [9:0]  x_int;
    logic [7:0]  fx;
    logic [9:0]  last_col;
    logic [10:0] x_int_p1;
    logic [9:0]  addr_a;
    logic [9:0]  addr_b;
    logic [10:0] cnt_next;
    logic [18:0] x_acc_sum;

    // Read tag line: valid, phase (1 = B) and fraction travel with each address
    logic        tag_valid [0:RD_LAT];
    logic        tag_b     [0:RD_LAT];
    logic [7:0]  tag_fx    [0:RD_LAT];
    logic        tags_any;

    // Capture and arithmetic pipeline
    logic [7:0]  p00;
    logic [7:0]  p10;
    logic [7:0]  t_val;
    logic [7:0]  b_val;
    logic        h_valid;
    logic [7:0]  out_px;
    logic        out_en;

    // Rounded Q8 blend of two samples: (a*(256-f) + b*f + 128) >> 8, saturated
    function automatic logic [7:0] blend(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] f);
        logic [8:0]  f_inv;
        logic [16:0] pa;
        logic [16:0] pb;
        logic [17:0] sum;
        logic [17:0] q;
        f_inv = 9'd256 - {1'b0, f};
        pa    = {9'd0, a} * {8'd0, f_inv};
        pb    = {9'd0, b} * {9'd0, f};
        sum   = {1'b0, pa} + {1'b0, pb} + 18'd128;
        q     = sum >> 8;
        return (q > 18'd255) ? 8'd255 : q[7:0];
    endfunction

    assign x_int     = x_acc[17:8];
    assign fx        = x_acc[7:0];
    assign last_col  = src_w_l - 10'd1;
    assign x_int_p1  = {1'b0, x_int} + 11'd1;
    assign addr_a    = (x_int > last_col) ? last_col : x_int;
    assign addr_b    = (x_int_p1 > {1'b0, last_col}) ? last_col : x_int_p1[9:0];
    assign cnt_next  = issue_cnt + 11'd1;
    assign x_acc_sum = {1'b0, x_acc} + {10'd0, x_step_l};

    // Line sequencer: issues A/B reads per pixel, then waits for the pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x_acc     <= '0;
            x_step_l  <= '0;
            fy_l      <= '0;
            src_w_l   <= '0;
            dst_w_l   <= '0;
            issue_cnt <= '0;
            rd_addr   <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.line_start) begin
                        x_step_l  <= bus.x_step;
                        fy_l      <= bus.fy;
                        src_w_l   <= bus.src_width;
                        dst_w_l   <= bus.dst_width;
                        x_acc     <= '0;
                        issue_cnt <= '0;
                        if (bus.src_width == 10'd0 || bus.dst_width == 11'd0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                        end else begin
                            state  <= ISSUE_A;
                            busy_r <= 1'b1;
                        end
                    end
                end
                ISSUE_A: begin
                    rd_addr <= addr_a;
                    state   <= ISSUE_B;
                end
                ISSUE_B: begin
                    rd_addr   <= addr_b;
                    // Saturate rather than wrap so oversized steps keep clamping right
                    x_acc     <= x_acc_sum[18] ? 18'h3FFFF : x_acc_sum[17:0];
                    issue_cnt <= cnt_next;
                    state     <= (cnt_next == dst_w_l) ? DRAIN : ISSUE_A;
                end
                DRAIN: begin
                    // Last pixel sits in stage H with nothing behind it: it leaves
                    // on this edge together with line_done
                    if (!tags_any && h_valid) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Any read still travelling through the tag line
    always_comb begin
        tags_any = 1'b0;
        for (int i = 0; i <= RD_LAT; i++) begin
            tags_any = tags_any | tag_valid[i];
        end
    end

    // Tag line shifted in step with the row-buffer read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_valid[i] <= 1'b0;
                tag_b[i]     <= 1'b0;
                tag_fx[i]    <= '0;
            end
        end else begin
            tag_valid[0] <= (state == ISSUE_A) || (state == ISSUE_B);
            tag_b[0]     <= (state == ISSUE_B);
            tag_fx[0]    <= fx;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_b[i]     <= tag_b[i-1];
                tag_fx[i]    <= tag_fx[i-1];
            end
        end
    end

    // A-phase holds the left taps; B-phase data goes straight into stage H
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p00     <= '0;
            p10     <= '0;
            t_val   <= '0;
            b_val   <= '0;
            h_valid <= 1'b0;
        end else begin
            h_valid <= 1'b0;
            if (tag_valid[RD_LAT] && !tag_b[RD_LAT]) begin
                p00 <= bus.row0_pixel;
                p10 <= bus.row1_pixel;
            end
            if (tag_valid[RD_LAT] && tag_b[RD_LAT]) begin
                t_val   <= blend(p00, bus.row0_pixel, tag_fx[RD_LAT]);
                b_val   <= blend(p10, bus.row1_pixel, tag_fx[RD_LAT]);
                h_valid <= 1'b1;
            end
        end
    end

    // Stage V: vertical blend; out_pixel holds between valid outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_px <= '0;
            out_en <= 1'b0;
        end else begin
            out_en <= h_valid;
            if (h_valid) begin
                out_px <= blend(t_val, b_val, fy_l);
            end
        end
    end

    assign bus.rd_row_addr = rd_addr;
    assign bus.out_pixel   = out_px;
    assign bus.out_data_en = out_en;
    assign bus.busy        = busy_r;
    assign bus.line_done   = done_r;

endmodule

// File: tb/tb_bilinear_col_interp.sv
// Directed bench for bilinear_col_interp with a registered-read row buffer model.
module tb_bilinear_col_interp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bilinear_col_interp_if bus();

    bilinear_col_interp #(.RD_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Row buffers: one clock of read latency
    logic [7:0] row0_mem [0:1023];
    logic [7:0] row1_mem [0:1023];
    always @(posedge clk) begin
        bus.row0_pixel <= row0_mem[bus.rd_row_addr];
        bus.row1_pixel <= row1_mem[bus.rd_row_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    int start_cyc = 0;

    logic [7:0] out_q[$];
    int         out_cyc_q[$];
    int         done_q[$];
    bit         done_en_q[$];

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.out_data_en === 1'b1) begin
            out_q.push_back(bus.out_pixel);
            out_cyc_q.push_back(cyc);
        end
        if (bus.line_done === 1'b1) begin
            done_q.push_back(cyc);
            done_en_q.push_back(bus.out_data_en);
        end
    end

    task automatic clear_mon();
        out_q.delete();
        out_cyc_q.delete();
        done_q.delete();
        done_en_q.delete();
    endtask

    task automatic fill_rows(input logic [7:0] v0, input logic [7:0] v1);
        for (int i = 0; i < 1024; i++) begin
            row0_mem[i] = v0;
            row1_mem[i] = v1;
        end
    endtask

    // Pulse line_start for one clock; start_cyc is the cycle index of that edge
    task automatic start_line(input logic [9:0] sw, input logic [10:0] dw,
                              input logic [8:0] xs, input logic [7:0] f);
        @(negedge clk);
        bus.src_width  = sw;
        bus.dst_width  = dw;
        bus.x_step     = xs;
        bus.fy         = f;
        bus.line_start = 1'b1;
        start_cyc      = cyc + 1;
        @(negedge clk);
        bus.line_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n;
        n = 0;
        while (done_q.size() == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = (done_q.size() != 0);
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fill_rows(8'd0, 8'd0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.out_data_en !== 1'b0) $display("FAIL reset_en: got %0b expected 0", bus.out_data_en);
        if (bus.out_data_en !== 1'b0) n_fail++;
        n_checks++;
        if (bus.out_pixel !== 8'd0) begin $display("FAIL reset_px: got %0d expected 0", bus.out_pixel); n_fail++; end
        n_checks++;
        if (bus.busy !== 1'b0) begin $display("FAIL reset_busy: got %0b expected 0", bus.busy); n_fail++; end
        n_checks++;
        if (bus.line_done !== 1'b0) begin $display("FAIL reset_done: got %0b expected 0", bus.line_done); n_fail++; end
        n_checks++;
        if (bus.rd_row_addr !== 10'd0) begin $display("FAIL reset_addr: got %0d expected 0", bus.rd_row_addr); n_fail++; end
        rst_n = 1'b1;
        clear_mon();
        repeat (8) @(negedge clk);
        n_checks++;
        if (out_q.size() + done_q.size() !== 0) begin
            $display("FAIL reset_idle_quiet: got %0d events expected 0", out_q.size() + done_q.size());
            n_fail++;
        end
        $display("test_reset: done");
    endtask

    task automatic test_upscale();
        logic [7:0] exp_px [0:7];
        bit ok;
        int last;
        exp_px = '{8'd0, 8'd50, 8'd100, 8'd150, 8'd200, 8'd225, 8'd250, 8'd250};
        fill_rows(8'd0, 8'd77);
        row0_mem[0] = 8'd0; row0_mem[1] = 8'd100; row0_mem[2] = 8'd200; row0_mem[3] = 8'd250;
        clear_mon();
        start_line(10'd4, 11'd8, 9'd128, 8'd0);
        wait_done(100, ok);
        n_checks++;
        if (!ok) begin $display("FAIL upscale_timeout: got no line_done expected one"); n_fail++; end
        n_checks++;
        if (out_q.size() !== 8) begin $display("FAIL upscale_count: got %0d expected 8", out_q.size()); n_fail++; end
        for (int k = 0; k < 8; k++) begin
            if (k < out_q.size()) begin
                n_checks++;
                if (out_q[k] !== exp_px[k]) begin
                    $display("FAIL upscale_px%0d: got %0d expected %0d", k, out_q[k], exp_px[k]);
                    n_fail++;
                end
                $display("upscale px%0d = %0d at cycle %0d", k, out_q[k], out_cyc_q[k] - start_cyc);
            end
            if (k > 0 && k < out_q.size()) begin
                n_checks++;
                if (out_cyc_q[k] - out_cyc_q[k-1] !== 2) begin
                    $display("FAIL upscale_gap%0d: got %0d expected 2", k, out_cyc_q[k] - out_cyc_q[k-1]);
                    n_fail++;
                end
            end
        end
        if (out_q.size() > 0) begin
            n_checks++;
            if (out_cyc_q[0] !== start_cyc + 5) begin
                $display("FAIL upscale_first_lat: got %0d expected %0d", out_cyc_q[0] - start_cyc, 5);
                n_fail++;
            end
        end
        if (done_q.size() > 0 && out_q.size() > 0) begin
            last = out_cyc_q[out_cyc_q.size() - 1];
            n_checks++;
            if (done_q[0] !== last || done_en_q[0] !== 1'b1) begin
                $display("FAIL upscale_done_align: got cycle %0d expected %0d", done_q[0], last);
                n_fail++;
            end
        end
    endtask

    task automatic test_vertical();
        bit ok;
        fill_rows(8'd0, 8'd255);
        clear_mon();
        start_line(10'd6, 11'd6, 9'd256, 8'd128);
        wait_done(100, ok);
        n_checks++;
        if (!ok || out_q.size() !== 6) begin
            $display("FAIL vertical_count: got %0d expected 6", out_q.size());
            n_fail++;
        end
        for (int k = 0; k < out_q.size(); k++) begin
            n_checks++;
            if (out_q[k] !== 8'd128) begin
                $display("FAIL vertical_px%0d: got %0d expected 128", k, out_q[k]);
                n_fail++;
            end
            $display("vertical px%0d = %0d", k, out_q[k]);
        end
    endtask

    task automatic test_identity();
        bit ok;
        int addr_bad, first_bad, px_bad, px_first;
        logic [9:0] exp_addr;
        fill_rows(8'd0, 8'hAA);
        for (int i = 0; i < 640; i++) row0_mem[i] = 8'(i);
        clear_mon();
        start_line(10'd640, 11'd640, 9'd256, 8'd0);
        addr_bad = 0;
        first_bad = -1;
        for (int j = 0; j < 1280; j++) begin
            @(negedge clk);
            if (j % 2 == 0) exp_addr = 10'(j / 2);
            else exp_addr = (j / 2 + 1 > 639) ? 10'd639 : 10'(j / 2 + 1);
            if (bus.rd_row_addr !== exp_addr) begin
                if (first_bad < 0) first_bad = j;
                addr_bad++;
            end
        end
        n_checks++;
        if (addr_bad !== 0) begin
            $display("FAIL identity_addr: got %0d bad addresses (first at read %0d) expected 0", addr_bad, first_bad);
            n_fail++;
        end
        wait_done(50, ok);
        n_checks++;
        if (!ok || out_q.size() !== 640) begin
            $display("FAIL identity_count: got %0d expected 640", out_q.size());
            n_fail++;
        end
        px_bad = 0;
        px_first = -1;
        for (int k = 0; k < out_q.size(); k++) begin
            if (out_q[k] !== 8'(k)) begin
                if (px_first < 0) px_first = k;
                px_bad++;
            end
        end
        n_checks++;
        if (px_bad !== 0) begin
            $display("FAIL identity_px: got %0d bad pixels (first at %0d) expected 0", px_bad, px_first);
            n_fail++;
        end
        $display("identity: %0d pixels, %0d address errors, %0d pixel errors", out_q.size(), addr_bad, px_bad);
    endtask

    task automatic test_zero_retrigger();
        bit ok;
        fill_rows(8'd0, 8'd0);
        clear_mon();
        start_line(10'd4, 11'd0, 9'd256, 8'd0);
        repeat (6) @(negedge clk);
        n_checks++;
        if (done_q.size() !== 1) begin $display("FAIL zero_done_count: got %0d expected 1", done_q.size()); n_fail++; end
        if (done_q.size() > 0) begin
            n_checks++;
            if (done_q[0] !== start_cyc) begin
                $display("FAIL zero_done_cycle: got %0d expected %0d", done_q[0] - start_cyc, 0);
                n_fail++;
            end
        end
        n_checks++;
        if (out_q.size() !== 0) begin $display("FAIL zero_no_output: got %0d expected 0", out_q.size()); n_fail++; end
        $display("zero width: line_done count %0d, outputs %0d", done_q.size(), out_q.size());

        for (int i = 0; i < 10; i++) row0_mem[i] = 8'(i * 20 + 3);
        clear_mon();
        start_line(10'd10, 11'd10, 9'd256, 8'd0);
        @(negedge clk);
        bus.src_width  = 10'd2;
        bus.dst_width  = 11'd3;
        bus.x_step     = 9'd64;
        bus.fy         = 8'd255;
        bus.line_start = 1'b1;
        @(negedge clk);
        bus.line_start = 1'b0;
        wait_done(100, ok);
        repeat (20) @(negedge clk);
        n_checks++;
        if (out_q.size() !== 10) begin $display("FAIL retrigger_count: got %0d expected 10", out_q.size()); n_fail++; end
        n_checks++;
        if (done_q.size() !== 1) begin $display("FAIL retrigger_done: got %0d expected 1", done_q.size()); n_fail++; end
        for (int k = 0; k < out_q.size(); k++) begin
            n_checks++;
            if (out_q[k] !== 8'(k * 20 + 3)) begin
                $display("FAIL retrigger_px%0d: got %0d expected %0d", k, out_q[k], k * 20 + 3);
                n_fail++;
            end
        end
        $display("retrigger: %0d outputs, %0d line_done", out_q.size(), done_q.size());
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        fill_rows(8'd0, 8'd0);
        for (int i = 0; i < 16; i++) row0_mem[i] = 8'(i * 10 + 5);
        clear_mon();
        start_line(10'd16, 11'd16, 9'd256, 8'd0);
        n = 0;
        while (out_q.size() < 3 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (out_q.size() !== 3) begin $display("FAIL midrst_reach3: got %0d expected 3", out_q.size()); n_fail++; end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_data_en !== 1'b0 || bus.out_pixel !== 8'd0) begin
            $display("FAIL midrst_out: got en=%0b px=%0d expected en=0 px=0", bus.out_data_en, bus.out_pixel);
            n_fail++;
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.line_done !== 1'b0 || bus.rd_row_addr !== 10'd0) begin
            $display("FAIL midrst_ctrl: got busy=%0b done=%0b addr=%0d expected 0 0 0",
                     bus.busy, bus.line_done, bus.rd_row_addr);
            n_fail++;
        end
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (out_q.size() !== 3 || done_q.size() !== 0) begin
            $display("FAIL midrst_quiet: got %0d outputs %0d done expected 3 outputs 0 done",
                     out_q.size(), done_q.size());
            n_fail++;
        end
        clear_mon();
        start_line(10'd16, 11'd16, 9'd256, 8'd0);
        wait_done(100, ok);
        n_checks++;
        if (!ok || out_q.size() !== 16) begin $display("FAIL midrst_relaunch_count: got %0d expected 16", out_q.size()); n_fail++; end
        for (int k = 0; k < out_q.size(); k++) begin
            n_checks++;
            if (out_q[k] !== 8'(k * 10 + 5)) begin
                $display("FAIL midrst_px%0d: got %0d expected %0d", k, out_q[k], k * 10 + 5);
                n_fail++;
            end
        end
        if (done_q.size() > 0 && out_q.size() > 0) begin
            n_checks++;
            if (done_q[0] !== out_cyc_q[out_cyc_q.size() - 1]) begin
                $display("FAIL midrst_done_align: got %0d expected %0d", done_q[0], out_cyc_q[out_cyc_q.size() - 1]);
                n_fail++;
            end
        end
        $display("reset mid-line: relaunch gave %0d outputs", out_q.size());
    endtask

    task automatic test_saturation();
        bit ok;
        fill_rows(8'd255, 8'd255);
        clear_mon();
        start_line(10'd7, 11'd12, 9'd171, 8'd200);
        wait_done(100, ok);
        n_checks++;
        if (!ok || out_q.size() !== 12) begin $display("FAIL sat_count: got %0d expected 12", out_q.size()); n_fail++; end
        for (int k = 0; k < out_q.size(); k++) begin
            n_checks++;
            if (out_q[k] !== 8'd255) begin
                $display("FAIL sat_px%0d: got %0d expected 255", k, out_q[k]);
                n_fail++;
            end
            $display("saturation px%0d = %0d", k, out_q[k]);
        end
    endtask

    initial begin
        bus.line_start = 1'b0;
        bus.src_width  = '0;
        bus.dst_width  = '0;
        bus.x_step     = '0;
        bus.fy         = '0;
        test_reset();
        test_upscale();
        test_vertical();
        test_identity();
        test_zero_retrigger();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
